// File: rtl/nios_ii_onchip_ram_pipelined_if.sv
// Avalon-MM pipelined bus bundle for nios_ii_onchip_ram_pipelined.
// The master drives the request side; the slave returns read data and back-pressure.
interface nios_ii_onchip_ram_pipelined_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15
);
  logic                  chipselect;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W/8-1:0]   byteenable;
  logic                  read;
  logic                  write;
  logic [DATA_W-1:0]     writedata;
  logic [DATA_W-1:0]     readdata;
  logic                  readdatavalid;
  logic                  waitrequest;

  modport master (
    output chipselect, address, byteenable, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  chipselect, address, byteenable, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/nios_ii_onchip_ram_pipelined.sv
// Parametrised single-port on-chip RAM with an Avalon-MM pipelined slave.
// Reads return through a READ_LATENCY-deep valid/data pipeline; writes are byte-masked.
// Optional build macro ONCHIP_RAM_CLEAR_EN: after reset, zero the whole RAM one word per
// enabled cycle while holding waitrequest high, then run.
module nios_ii_onchip_ram_pipelined #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 15,
  parameter int DEPTH        = 16392,
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic reset_req,
  input  logic clken,
  nios_ii_onchip_ram_pipelined_if.slave bus
);

  localparam int NB = DATA_W / 8;

  typedef enum logic {ST_RUN, ST_CLEAR} state_t;

  state_t            state_q, state_d;
  logic              clearing;
  logic              stall;
  logic              in_range;
  logic              acc;
  logic              wr_acc;
  logic              rd_acc;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [READ_LATENCY-1:0] vld_q;
  logic [DATA_W-1:0]       dat_q [READ_LATENCY];

`ifdef ONCHIP_RAM_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr_q;
`endif

  // State register (and clear sweep pointer when the clear build is selected)
  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef ONCHIP_RAM_CLEAR_EN
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
`else
      state_q    <= ST_RUN;
`endif
    end else begin
      state_q <= state_d;
`ifdef ONCHIP_RAM_CLEAR_EN
      if (state_q == ST_CLEAR && clken)
        clr_addr_q <= clr_addr_q + 1'b1;
`endif
    end
  end

  // Next state: leave CLEAR once the last word has been zeroed
  always_comb begin
    state_d = state_q;
`ifdef ONCHIP_RAM_CLEAR_EN
    if (state_q == ST_CLEAR && clken && clr_addr_q == ADDR_W'(DEPTH - 1))
      state_d = ST_RUN;
`else
    state_d = ST_RUN;
`endif
  end

  // Outputs of the FSM and bus acceptance decode
  always_comb begin
    clearing = (state_q == ST_CLEAR);
    stall    = reset | reset_req | ~clken | clearing;
    in_range = (32'(bus.address) < DEPTH);
    acc      = bus.chipselect & (bus.read | bus.write) & ~stall;
    wr_acc   = acc & bus.write;
    // A combined read+write is treated as a write only.
    rd_acc   = acc & bus.read & ~bus.write;
  end

  assign bus.waitrequest   = stall;
  assign bus.readdatavalid = vld_q[READ_LATENCY-1];
  assign bus.readdata      = dat_q[READ_LATENCY-1];

  // RAM array: clear sweep or byte-masked bus write; contents are never reset
  always_ff @(posedge clk) begin
`ifdef ONCHIP_RAM_CLEAR_EN
    if (!reset && clearing && clken)
      mem[clr_addr_q] <= '0;
`endif
    if (wr_acc && in_range) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (bus.byteenable[i])
          mem[bus.address][i*8 +: 8] <= bus.writedata[i*8 +: 8];
      end
    end
  end

  // Read pipeline: advances only on enabled cycles, so a frozen pulse is never replayed
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++)
        dat_q[i] <= '0;
    end else if (clken) begin
      vld_q[0] <= rd_acc;
      dat_q[0] <= (rd_acc && in_range) ? mem[bus.address] : '0;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_nios_ii_onchip_ram_pipelined.sv
// Scoreboard bench for nios_ii_onchip_ram_pipelined: three instances with READ_LATENCY 1..3
// share one stimulus stream; each has its own expected-read queue and monitor.
module tb_nios_ii_onchip_ram_pipelined;

  localparam int DEPTH = 16392;
`ifdef ONCHIP_RAM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reset_req = 1'b0;
  logic        clken = 1'b1;
  logic        chipselect = 1'b0;
  logic [14:0] address = '0;
  logic [3:0]  byteenable = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;

  logic [2:0]  wreq;
  logic [2:0]  rdv;
  logic [31:0] rdd [3];

  int          n_chk = 0;
  int          n_fail = 0;
  int          ecyc = 0;      // count of clock-enabled edges outside reset
  int          clr_left = 0;  // words the clear sweep still has to write
  exp_t        expq [3][$];
  logic [31:0] mdl [int];     // reference memory: word address -> contents
  int          pool [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    nios_ii_onchip_ram_pipelined_if #(.DATA_W(32), .ADDR_W(15)) bus ();

    assign bus.chipselect = chipselect;
    assign bus.address    = address;
    assign bus.byteenable = byteenable;
    assign bus.read       = read;
    assign bus.write      = write;
    assign bus.writedata  = writedata;
    assign wreq[g]        = bus.waitrequest;
    assign rdv[g]         = bus.readdatavalid;
    assign rdd[g]         = bus.readdata;

    nios_ii_onchip_ram_pipelined #(
      .DATA_W(32), .ADDR_W(15), .DEPTH(DEPTH), .READ_LATENCY(g + 1)
    ) dut (
      .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .bus(bus)
    );

    // Monitor: a pulse counts only on an enabled cycle, when the master also samples it
    always @(negedge clk) begin
      if (!reset && clken) begin
        if (rdv[g]) begin
          n_chk++;
          if (expq[g].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_rdv lat%0d: got readdata %h, required no readdatavalid", g + 1, rdd[g]);
          end else begin
            exp_t e;
            e = expq[g].pop_front();
            if (rdd[g] !== e.data || ecyc != e.due) begin
              n_fail++;
              $display("FAIL read_data lat%0d: got %h at cycle %0d, required %h at cycle %0d",
                       g + 1, rdd[g], ecyc, e.data, e.due);
            end
          end
        end else if (expq[g].size() > 0 && expq[g][0].due <= ecyc) begin
          exp_t e;
          e = expq[g].pop_front();
          n_chk++;
          n_fail++;
          $display("FAIL missing_rdv lat%0d: got no readdatavalid at cycle %0d, required %h", g + 1, ecyc, e.data);
        end
      end
    end
  end

  function automatic logic [31:0] exp_read(input int a);
    if (a >= DEPTH) return 32'h0;
    if (mdl.exists(a)) return mdl[a];
    return 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  // One bus cycle: drive, check waitrequest mid-cycle, then update the reference at the edge.
  task automatic step(input logic cs, input logic rd, input logic wr, input int addr,
                      input logic [3:0] be, input logic [31:0] wd, input logic ce,
                      input logic rq, input logic rs, output logic accepted);
    logic        ew;
    logic [31:0] cur;
    chipselect = cs; read = rd; write = wr; address = 15'(addr);
    byteenable = be; writedata = wd; clken = ce; reset_req = rq; reset = rs;
    @(negedge clk);
    ew = rs | rq | ~ce | (clr_left > 0);
    for (int g = 0; g < 3; g++) check($sformatf("waitrequest lat%0d", g + 1), 32'(wreq[g]), 32'(ew));
    accepted = cs && (rd || wr) && !ew;
    @(posedge clk);
    if (rs) begin
      for (int g = 0; g < 3; g++) expq[g].delete();
      clr_left = CLR ? DEPTH : 0;
      if (CLR) mdl.delete();
    end else begin
      if (accepted && wr && addr < DEPTH) begin
        cur = exp_read(addr);
        for (int b = 0; b < 4; b++)
          if (be[b]) cur[b*8 +: 8] = wd[b*8 +: 8];
        mdl[addr] = cur;
      end
      if (ce) ecyc++;
      if (ce && clr_left > 0) clr_left--;
      if (accepted && rd && !wr)
        for (int g = 0; g < 3; g++) expq[g].push_back('{exp_read(addr), ecyc + g});
    end
    #1;
  endtask

  task automatic idle();
    logic a;
    step(1'b0, 1'b0, 1'b0, 0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, a);
  endtask

  task automatic wr_t(input int addr, input logic [31:0] d, input logic [3:0] be);
    logic a;
    step(1'b1, 1'b0, 1'b1, addr, be, d, 1'b1, 1'b0, 1'b0, a);
  endtask

  task automatic rd_t(input int addr);
    logic a;
    step(1'b1, 1'b1, 1'b0, addr, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, a);
  endtask

  task automatic rst_t();
    logic a;
    step(1'b0, 1'b0, 1'b0, 0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, a);
  endtask

  task automatic wait_clear();
    for (int i = 0; i < DEPTH + 4 && clr_left > 0; i++) idle();
  endtask

  initial begin
    logic acc;
    int   a;

    for (int i = 0; i < 48; i++) pool.push_back(i);
    for (int i = DEPTH - 8; i < DEPTH + 4; i++) pool.push_back(i);

    // Reset state, then a second reset part-way through any clear sweep
    rst_t();
    rst_t();
    for (int g = 0; g < 3; g++) begin
      check($sformatf("reset_rdv lat%0d", g + 1), 32'(rdv[g]), 32'h0);
      check($sformatf("reset_readdata lat%0d", g + 1), rdd[g], 32'h0);
    end
    for (int i = 0; i < 30; i++) idle();
    rst_t();
    wait_clear();

    // After a clear sweep every word reads back as zero
    if (CLR) begin
      rd_t(0); rd_t(DEPTH - 1); rd_t(17);
    end

    // Prefill the in-range part of the address pool
    foreach (pool[i]) if (pool[i] < DEPTH) wr_t(pool[i], $urandom, 4'hF);

    // Full-word write and readback
    wr_t(16'h10, 32'hDEADBEEF, 4'hF);
    rd_t(16'h10);

    // Byte-masked write over a known word
    wr_t(5, 32'hAABBCCDD, 4'hF);
    wr_t(5, 32'h11223344, 4'b0101);
    rd_t(5);

    // Back-to-back reads
    for (int i = 0; i < 8; i++) rd_t(i);

    // Out-of-range write is dropped; out-of-range read returns zero; word 0 intact
    wr_t(DEPTH, $urandom, 4'hF);
    rd_t(DEPTH);
    rd_t(0);

    // Combined read+write performs only the write; deselected read is ignored
    step(1'b1, 1'b1, 1'b1, 7, 4'hF, 32'h5A5AA5A5, 1'b1, 1'b0, 1'b0, acc);
    step(1'b0, 1'b1, 1'b0, 7, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
    rd_t(7);

    // Burst with clken low for 4 cycles in the middle; master holds its request
    a = 0;
    for (int k = 0; k < 20 && a < 8; k++) begin
      step(1'b1, 1'b1, 1'b0, a, 4'h0, 32'h0, !(k >= 3 && k <= 6), 1'b0, 1'b0, acc);
      if (acc) a++;
    end

    // reset_req stalls new requests while in-flight reads still finish
    rd_t(1); rd_t(2);
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b1, 1'b0, 3, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, acc);
    rd_t(3);

    // Randomised traffic with stalls
    for (int k = 0; k < 500; k++) begin
      logic cs, rd, wr;
      cs = ($urandom_range(0, 9) != 0);
      rd = $urandom_range(0, 1) == 1;
      wr = ($urandom_range(0, 3) == 0);
      step(cs, rd, wr, pool[$urandom_range(0, pool.size() - 1)], 4'($urandom), $urandom,
           ($urandom_range(0, 6) != 0), ($urandom_range(0, 9) == 0), 1'b0, acc);
    end

    // Reset with reads in flight: they are discarded
    rd_t(4); rd_t(5); rd_t(6);
    rst_t();
    for (int g = 0; g < 3; g++) check($sformatf("midreset_rdv lat%0d", g + 1), 32'(rdv[g]), 32'h0);
    wait_clear();
    rd_t(4); rd_t(DEPTH - 1);

    for (int i = 0; i < 8; i++) idle();
    for (int g = 0; g < 3; g++)
      check($sformatf("queue_drained lat%0d", g + 1), 32'(expq[g].size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
